// File: rtl/reg_wr_arb_pkg.sv
// reg_wr_arb_pkg: state encoding and width helpers shared by the register-write arbiter
package reg_wr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int idx_w(input int n_req);
        return (n_req > 2) ? $clog2(n_req) : 1;
    endfunction

    function automatic int tmo_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/reg_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request searching from ptr+1
module rr_pick
    import reg_wr_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // scan from farthest to nearest after ptr so the nearest set bit is the final assignment
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin sharing of one register-write port; REG_WR_ARB_TIMEOUT_EN adds stall abort
module reg_wr_arbiter
    import reg_wr_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 40,
    parameter int STRB_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_wr_en,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_wr_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wr_data,
    input  logic [N_REQ*STRB_WIDTH-1:0] req_wr_strb,
    output logic [N_REQ-1:0]            req_wr_wait,
    output logic [N_REQ-1:0]            req_wr_ack,
    output logic [N_REQ-1:0]            req_wr_err,
    output logic [ADDR_WIDTH-1:0]       m_reg_wr_addr,
    output logic [DATA_WIDTH-1:0]       m_reg_wr_data,
    output logic [STRB_WIDTH-1:0]       m_reg_wr_strb,
    output logic                        m_reg_wr_en,
    input  logic                        m_reg_wr_wait,
    input  logic                        m_reg_wr_ack
);

    localparam int IW = idx_w(N_REQ);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          tmo;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req   (req_wr_en),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

`ifdef REG_WR_ARB_TIMEOUT_EN
    localparam int TW = tmo_w(TIMEOUT);

    logic [TW-1:0] cnt;

    // reload while idle, count down only on BUSY cycles the downstream is not stalling
    always_ff @(posedge clk) begin
        if (!rstn)
            cnt <= '0;
        else if (state == IDLE)
            cnt <= TW'(TIMEOUT - 1);
        else if (state == BUSY && cnt != '0 && !m_reg_wr_wait)
            cnt <= cnt - 1'b1;
    end

    assign tmo = (cnt == '0);
`else
    logic unused_tmo;

    assign tmo        = 1'b0;
    assign unused_tmo = m_reg_wr_wait ^ (TIMEOUT > 1);
`endif

    // grant, hold the sampled write on the port, then pulse ack/err for one cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            ptr           <= IW'(N_REQ - 1);
            g             <= '0;
            m_reg_wr_addr <= '0;
            m_reg_wr_data <= '0;
            m_reg_wr_strb <= '0;
            m_reg_wr_en   <= 1'b0;
            req_wr_ack    <= '0;
            req_wr_err    <= '0;
        end else begin
            req_wr_ack <= '0;
            req_wr_err <= '0;
            case (state)
                IDLE: if (pick_vld) begin
                    g             <= pick_idx;
                    m_reg_wr_addr <= req_wr_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    m_reg_wr_data <= req_wr_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                    m_reg_wr_strb <= req_wr_strb[int'(pick_idx)*STRB_WIDTH +: STRB_WIDTH];
                    m_reg_wr_en   <= 1'b1;
                    state         <= BUSY;
                end
                BUSY: if (m_reg_wr_ack || tmo) begin
                    m_reg_wr_en   <= 1'b0;
                    req_wr_ack[g] <= 1'b1;
                    req_wr_err[g] <= !m_reg_wr_ack;
                    state         <= RESP;
                end
                RESP: begin
                    ptr   <= g;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a request stays pending until the cycle its ack is presented
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            req_wr_wait[i] = req_wr_en[i] && !(state == RESP && g == IW'(i));
    end

endmodule
